// File: rtl/cheat_multi_if.sv
// cheat_multi_if: SNES bus, programming and status signals of the cheat engine.
// The master modport drives stimulus; the slave modport is the engine side.
interface cheat_multi_if #(
  parameter int IDX_W = 4
);
  logic [23:0]      SNES_ADDR;
  logic             SNES_rd_strobe;
  logic             SNES_reset_strobe;
  logic             pgm_we;
  logic [IDX_W-1:0] pgm_idx;
  logic [1:0]       pgm_sel;
  logic [31:0]      pgm_in;
  logic [IDX_W-1:0] stat_idx;
  logic [15:0]      stat_out;
  logic [7:0]       data_out;
  logic             cheat_hit;

  modport master (
    output SNES_ADDR, SNES_rd_strobe, SNES_reset_strobe,
    output pgm_we, pgm_idx, pgm_sel, pgm_in, stat_idx,
    input  stat_out, data_out, cheat_hit
  );

  modport slave (
    input  SNES_ADDR, SNES_rd_strobe, SNES_reset_strobe,
    input  pgm_we, pgm_idx, pgm_sel, pgm_in, stat_idx,
    output stat_out, data_out, cheat_hit
  );
endinterface

// File: rtl/cheat_multi.sv
// cheat_multi: multi-slot SNES byte-patch engine with lowest-index priority and post-reset holdoff.
// Define CHEAT_HITCNT_EN to add saturating per-slot hit counters readable on stat_out.
module cheat_multi #(
  parameter int NUM_SLOTS      = 16,
  parameter int HOLDOFF_CYCLES = 960000000,
  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  cheat_multi_if.slave bus
);

  localparam logic [29:0] HOLDOFF_LOAD = 30'(HOLDOFF_CYCLES);

  logic [23:0]          slot_addr [NUM_SLOTS];
  logic [7:0]           slot_data [NUM_SLOTS];
  logic [23:0]          slot_mask [NUM_SLOTS];
  logic [7:0]           slot_rem  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_en;
  logic [NUM_SLOTS-1:0] slot_oneshot;
  logic                 global_en;
  logic                 holdoff_en;
  logic [29:0]          holdoff_cnt;

  logic [NUM_SLOTS-1:0] match;
  logic [NUM_SLOTS-1:0] winner;
  logic [NUM_SLOTS-1:0] pgm_hit;
  logic [7:0]           win_data;
  logic                 hit;
  logic                 take;
  logic                 pgm_slot;
  logic                 pgm_glob;

  assign pgm_slot = bus.pgm_we && (bus.pgm_sel != 2'd3) && (int'(bus.pgm_idx) < NUM_SLOTS);
  assign pgm_glob = bus.pgm_we && (bus.pgm_sel == 2'd3);

  always_comb begin
    match   = '0;
    pgm_hit = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      match[i]   = slot_en[i]
                   && (((bus.SNES_ADDR ^ slot_addr[i]) & ~slot_mask[i]) == 24'h000000)
                   && (!slot_oneshot[i] || (slot_rem[i] != 8'h00));
      pgm_hit[i] = pgm_slot && (int'(bus.pgm_idx) == i);
    end
  end

  // Isolate the lowest set bit: the lowest-index match wins.
  assign winner = match & (~match + NUM_SLOTS'(1));

  always_comb begin
    win_data = 8'h00;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (winner[i]) win_data = slot_data[i];
    end
  end

  assign hit          = global_en && (|match) && (holdoff_cnt == 30'd0);
  assign take         = hit && bus.SNES_rd_strobe;
  assign bus.data_out = win_data;
  assign bus.cheat_hit = hit;

  // A program write to a slot overrides any one-shot decrement landing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_addr[i] <= 24'h000000;
        slot_data[i] <= 8'h00;
        slot_mask[i] <= 24'h000000;
        slot_rem[i]  <= 8'h00;
      end
      slot_en      <= '0;
      slot_oneshot <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (pgm_hit[i]) begin
          case (bus.pgm_sel)
            2'd0: begin
              slot_addr[i] <= bus.pgm_in[31:8];
              slot_data[i] <= bus.pgm_in[7:0];
            end
            2'd1: slot_mask[i] <= bus.pgm_in[23:0];
            2'd2: begin
              slot_en[i]      <= bus.pgm_in[0];
              slot_oneshot[i] <= bus.pgm_in[1];
              slot_rem[i]     <= bus.pgm_in[15:8];
            end
            default: ;
          endcase
        end else if (take && winner[i] && slot_oneshot[i]) begin
          slot_rem[i] <= slot_rem[i] - 8'd1;
          if (slot_rem[i] == 8'd1) slot_en[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      global_en   <= 1'b0;
      holdoff_en  <= 1'b0;
      holdoff_cnt <= 30'd0;
    end else begin
      if (pgm_glob) begin
        global_en  <= bus.pgm_in[0];
        holdoff_en <= bus.pgm_in[1];
      end
      if (bus.SNES_reset_strobe && holdoff_en) begin
        holdoff_cnt <= HOLDOFF_LOAD;
      end else if (holdoff_cnt != 30'd0) begin
        holdoff_cnt <= holdoff_cnt - 30'd1;
      end
    end
  end

`ifdef CHEAT_HITCNT_EN
  logic [15:0] hit_cnt [NUM_SLOTS];
  logic [15:0] stat_sel;
  logic [15:0] stat_q;
  logic        cnt_clr;

  assign cnt_clr = pgm_glob && bus.pgm_in[2];

  always_comb begin
    stat_sel = 16'h0000;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (int'(bus.stat_idx) == i) stat_sel = hit_cnt[i];
    end
  end

  // A global clear beats an increment on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SLOTS; i++) hit_cnt[i] <= 16'h0000;
      stat_q <= 16'h0000;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (cnt_clr) begin
          hit_cnt[i] <= 16'h0000;
        end else if (take && winner[i] && (hit_cnt[i] != 16'hFFFF)) begin
          hit_cnt[i] <= hit_cnt[i] + 16'd1;
        end
      end
      stat_q <= stat_sel;
    end
  end

  assign bus.stat_out = stat_q;
`else
  logic unused_stat;
  assign unused_stat  = ^bus.stat_idx;
  assign bus.stat_out = 16'h0000;
`endif

endmodule

// File: tb/tb_cheat_multi.sv
// tb_cheat_multi: directed and randomized checks of cheat_multi against a slot-level behavioural model.
// Honours CHEAT_HITCNT_EN the same way as the design.
module tb_cheat_multi;
  localparam int NS   = 6;
  localparam int IW   = 3;
  localparam int HOLD = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  cheat_multi_if #(.IDX_W(IW)) bus ();

  cheat_multi #(.NUM_SLOTS(NS), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  data;
    logic [23:0] mask;
    bit          en;
    bit          os;
    int          rem;
    int          hits;
  } slot_t;

  slot_t       m [NS];
  bit          m_gen;
  bit          m_hen;
  int          m_hold;
  logic [15:0] m_stat;

  function automatic int modelWinner(input logic [23:0] a);
    for (int i = 0; i < NS; i++) begin
      if (m[i].en && (((a ^ m[i].addr) & ~m[i].mask) == 24'h0) && (!m[i].os || m[i].rem > 0))
        return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NS; i++) begin
      m[i].addr = 24'h0; m[i].data = 8'h0; m[i].mask = 24'h0;
      m[i].en = 1'b0; m[i].os = 1'b0; m[i].rem = 0; m[i].hits = 0;
    end
    m_gen = 1'b0; m_hen = 1'b0; m_hold = 0; m_stat = 16'h0;
  endtask

  task automatic modelStep();
    int w;
    int idx;
    bit hit;
    bit slot_wr;
    w       = modelWinner(bus.SNES_ADDR);
    hit     = m_gen && (w >= 0) && (m_hold == 0);
    idx     = int'(bus.pgm_idx);
    slot_wr = bus.pgm_we && (bus.pgm_sel != 2'd3) && (idx < NS);
`ifdef CHEAT_HITCNT_EN
    if (int'(bus.stat_idx) < NS) m_stat = 16'(m[int'(bus.stat_idx)].hits);
    else m_stat = 16'h0;
`endif
    if (bus.SNES_rd_strobe && hit) begin
      if (m[w].os && !(slot_wr && idx == w)) begin
        m[w].rem = m[w].rem - 1;
        if (m[w].rem == 0) m[w].en = 1'b0;
      end
      if (m[w].hits < 65535) m[w].hits = m[w].hits + 1;
    end
    if (bus.SNES_reset_strobe && m_hen) m_hold = HOLD;
    else if (m_hold > 0) m_hold = m_hold - 1;
    if (bus.pgm_we && bus.pgm_sel == 2'd3) begin
      m_gen = bus.pgm_in[0];
      m_hen = bus.pgm_in[1];
      if (bus.pgm_in[2]) for (int i = 0; i < NS; i++) m[i].hits = 0;
    end
    if (slot_wr) begin
      case (bus.pgm_sel)
        2'd0: begin m[idx].addr = bus.pgm_in[31:8]; m[idx].data = bus.pgm_in[7:0]; end
        2'd1: m[idx].mask = bus.pgm_in[23:0];
        default: begin
          m[idx].en  = bus.pgm_in[0];
          m[idx].os  = bus.pgm_in[1];
          m[idx].rem = int'(bus.pgm_in[15:8]);
        end
      endcase
    end
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Every negedge: outputs against the model's view of the current address.
  initial begin
    int w;
    forever begin
      @(negedge clk);
      w = modelWinner(bus.SNES_ADDR);
      checkOutput("cyc_hit", 16'(bus.cheat_hit), 16'(m_gen && (w >= 0) && (m_hold == 0)));
      checkOutput("cyc_data", 16'(bus.data_out), (w >= 0) ? 16'(m[w].data) : 16'h0);
      checkOutput("cyc_stat", bus.stat_out, m_stat);
    end
  end

  task automatic applyStimulus(input logic [23:0] a, input bit rd, input bit rs,
                               input bit we, input int idx, input int sel, input logic [31:0] din);
    @(posedge clk);
    #1;
    bus.SNES_ADDR         = a;
    bus.SNES_rd_strobe    = rd;
    bus.SNES_reset_strobe = rs;
    bus.pgm_we            = we;
    bus.pgm_idx           = IW'(idx);
    bus.pgm_sel           = 2'(sel);
    bus.pgm_in            = din;
    @(negedge clk);
  endtask

  task automatic prog(input int idx, input int sel, input logic [31:0] din);
    applyStimulus(24'h0, 1'b0, 1'b0, 1'b1, idx, sel, din);
  endtask

  task automatic idle(input logic [23:0] a);
    applyStimulus(a, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
  endtask

  logic [23:0] pool  [4];
  logic [23:0] masks [4];

  initial begin
    int nh;
    int nz;
    pool[0] = 24'h00FFEA; pool[1] = 24'h7E0010; pool[2] = 24'h001234; pool[3] = 24'h00ABCD;
    masks[0] = 24'h000000; masks[1] = 24'h00000F; masks[2] = 24'h00FFFF; masks[3] = 24'h000001;
    bus.SNES_ADDR = 24'h00FFEA; bus.SNES_rd_strobe = 1'b0; bus.SNES_reset_strobe = 1'b0;
    bus.pgm_we = 1'b0; bus.pgm_idx = '0; bus.pgm_sel = 2'd0; bus.pgm_in = 32'h0; bus.stat_idx = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_data", 16'(bus.data_out), 16'h0000);
    checkOutput("rst_hit", 16'(bus.cheat_hit), 16'h0000);
    checkOutput("rst_stat", bus.stat_out, 16'h0000);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);

    // Single slot substitution.
    prog(3, 0, {24'h00FFEA, 8'h5C});
    prog(3, 2, 32'h1);
    prog(0, 3, 32'h1);
    idle(24'h00FFEA);
    checkOutput("r36_data", 16'(bus.data_out), 16'h005C);
    checkOutput("r36_hit", 16'(bus.cheat_hit), 16'h0001);
    idle(24'h00FFEB);
    checkOutput("r36_miss_hit", 16'(bus.cheat_hit), 16'h0000);
    checkOutput("r36_miss_data", 16'(bus.data_out), 16'h0000);
    prog(3, 2, 32'h0);

    // Priority between overlapping slots; out-of-range index is ignored.
    prog(2, 0, {24'h7E0010, 8'hA1});
    prog(2, 2, 32'h1);
    prog(5, 0, {24'h7E0000, 8'hB2});
    prog(5, 1, 32'h0000FFFF);
    prog(5, 2, 32'h1);
    prog(7, 0, {24'h7E0010, 8'hEE});
    prog(7, 2, 32'h1);
    idle(24'h7E0010);
    checkOutput("r37_lowest", 16'(bus.data_out), 16'h00A1);
    prog(2, 2, 32'h0);
    idle(24'h7E0010);
    checkOutput("r37_next", 16'(bus.data_out), 16'h00B2);
    idle(24'h7F0010);
    checkOutput("r37_nohit", 16'(bus.cheat_hit), 16'h0000);
    prog(5, 2, 32'h0);

    // One-shot slot runs out after two hits.
    prog(0, 0, {24'h001234, 8'h77});
    prog(0, 2, 32'h0000_0203);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(24'h001234, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0);
      checkOutput($sformatf("r38_hit%0d", k), 16'(bus.cheat_hit), (k < 2) ? 16'h1 : 16'h0);
    end
    idle(24'h001234);
    checkOutput("r38_spent_data", 16'(bus.data_out), 16'h0000);

    // Reprogram coinciding with a decrement keeps the programmed count.
    prog(0, 2, 32'h0000_0103);
    applyStimulus(24'h001234, 1'b1, 1'b0, 1'b1, 0, 2, 32'h0000_0903);
    checkOutput("r41_first", 16'(bus.cheat_hit), 16'h0001);
    nh = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(24'h001234, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0);
      if (bus.cheat_hit) nh++;
    end
    checkOutput("r41_hits", 16'(nh), 16'd9);

    // Holdoff window, reload while active, then async reset mid-holdoff.
    prog(0, 2, 32'h1);
    prog(0, 3, 32'h3);
    applyStimulus(24'h001234, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0);
    checkOutput("r39_pre", 16'(bus.cheat_hit), 16'h0001);
    nz = 0;
    for (int k = 0; k < HOLD; k++) begin
      idle(24'h001234);
      if (!bus.cheat_hit) nz++;
    end
    checkOutput("r39_blocked", 16'(nz), 16'(HOLD));
    idle(24'h001234);
    checkOutput("r39_after", 16'(bus.cheat_hit), 16'h0001);
    applyStimulus(24'h001234, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0);
    repeat (50) idle(24'h001234);
    applyStimulus(24'h001234, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0);
    repeat (60) idle(24'h001234);
    checkOutput("r39_reload", 16'(bus.cheat_hit), 16'h0000);
    @(posedge clk); #1; rst_n = 1'b0;
    @(negedge clk);
    checkOutput("r39_rst_hit", 16'(bus.cheat_hit), 16'h0000);
    checkOutput("r39_rst_data", 16'(bus.data_out), 16'h0000);
    @(posedge clk); #1; rst_n = 1'b1;
    prog(0, 3, 32'h1);
    idle(24'h001234);
    checkOutput("r39_cleared", 16'(bus.data_out), 16'h0000);

`ifdef CHEAT_HITCNT_EN
    // Hit counter saturation, clear and out-of-range readout.
    prog(1, 0, {24'h00ABCD, 8'h11});
    prog(1, 2, 32'h1);
    bus.stat_idx = 3'd1;
    for (int k = 0; k < 70000; k++) applyStimulus(24'h00ABCD, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0);
    idle(24'h00ABCD);
    idle(24'h00ABCD);
    checkOutput("r40_sat", bus.stat_out, 16'hFFFF);
    prog(0, 3, 32'h5);
    idle(24'h00ABCD);
    idle(24'h00ABCD);
    checkOutput("r40_clear", bus.stat_out, 16'h0000);
    repeat (5) applyStimulus(24'h00ABCD, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0);
    idle(24'h00ABCD);
    idle(24'h00ABCD);
    checkOutput("r40_five", bus.stat_out, 16'h0005);
    bus.stat_idx = 3'd7;
    idle(24'h00ABCD);
    idle(24'h00ABCD);
    checkOutput("r40_oob", bus.stat_out, 16'h0000);
`endif

    // Randomized traffic; the per-cycle compare does the checking.
    for (int n = 0; n < 3000; n++) begin
      logic [23:0] a;
      logic [31:0] din;
      int          sel;
      bit          we;
      a = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) a = a ^ (24'h1 << $urandom_range(0, 23));
      we  = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 3);
      case (sel)
        0: din = {pool[$urandom_range(0, 3)], 8'($urandom)};
        1: din = {8'h0, masks[$urandom_range(0, 3)]};
        2: din = {16'h0, 8'($urandom_range(0, 3)), 6'h0, 1'($urandom), ($urandom_range(0, 3) != 0)};
        default: din = {29'h0, ($urandom_range(0, 7) == 0), 1'($urandom), ($urandom_range(0, 9) != 0)};
      endcase
      bus.stat_idx = IW'($urandom_range(0, 7));
      applyStimulus(a, 1'($urandom), ($urandom_range(0, 49) == 0), we, $urandom_range(0, 7), sel, din);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
